// File: rtl/pixel_streamer.sv
// Frame-buffered raster pixel source feeding the streaming side of a conv2d window buffer.
// Build option PIXEL_STREAMER_ZERO_PAD_EN wraps the frame in a zero border of (K_KERNEL-1)/2 pixels.
module pixel_streamer #(
  parameter int N_IMAGE  = 8,
  parameter int K_KERNEL = 3,
  parameter int BWD      = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_wr_en,
  input  logic [$clog2(N_IMAGE*N_IMAGE)-1:0] i_wr_addr,
  input  logic [BWD-1:0]                     i_wr_data,
  input  logic                               i_start,
  input  logic                               i_ready,
  output logic                               o_clear,
  output logic [BWD-1:0]                     o_data,
  output logic                               o_data_valid,
  output logic                               o_frame_end,
  output logic                               o_busy,
  output logic                               o_done
);
  localparam int AW  = $clog2(N_IMAGE*N_IMAGE);
  localparam int PAD = (K_KERNEL-1)/2;
`ifdef PIXEL_STREAMER_ZERO_PAD_EN
  localparam int PAD_EN = 1;
`else
  localparam int PAD_EN = 0;
`endif
  localparam int NS = N_IMAGE + 2*PAD*PAD_EN;
  localparam int CW = $clog2(NS);
  localparam logic [CW-1:0] POS_LAST  = CW'(NS-1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(N_IMAGE*N_IMAGE-1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLEAR  = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [BWD-1:0]  r_mem [N_IMAGE*N_IMAGE];
  logic [CW-1:0]   r_row;
  logic [CW-1:0]   r_col;
  logic [AW-1:0]   r_addr;
  logic [BWD-1:0]  r_data;
  logic            r_clear;
  logic            r_valid;
  logic            r_frame_end;
  logic            r_busy;
  logic            r_done;
  logic            w_issue;
  logic            w_last_pos;
  logic            w_interior;
  logic            w_clear_nxt;
  logic            w_valid_nxt;
  logic            w_frame_end_nxt;
  logic            w_busy_nxt;
  logic            w_done_nxt;

  assign w_issue    = (r_state == S_STREAM) && i_ready;
  assign w_last_pos = (r_row == POS_LAST) && (r_col == POS_LAST);
`ifdef PIXEL_STREAMER_ZERO_PAD_EN
  localparam logic [CW-1:0] P_LO = CW'(PAD);
  localparam logic [CW-1:0] P_HI = CW'(PAD + N_IMAGE);
  assign w_interior = (r_row >= P_LO) && (r_row < P_HI) && (r_col >= P_LO) && (r_col < P_HI);
`else
  assign w_interior = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next_state = S_CLEAR;
        else         w_next_state = S_IDLE;
      end
      S_CLEAR: w_next_state = S_STREAM;
      S_STREAM: begin
        if (w_issue && w_last_pos) w_next_state = S_DRAIN;
        else                       w_next_state = S_STREAM;
      end
      S_DRAIN: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode: next values of the registered outputs
  always_comb begin
    w_clear_nxt     = (r_state == S_IDLE) && i_start;
    w_valid_nxt     = w_issue;
    w_frame_end_nxt = w_issue && w_last_pos;
    w_done_nxt      = (r_state == S_DRAIN);
    w_busy_nxt      = (w_next_state != S_IDLE);
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clear     <= 1'b0;
      r_valid     <= 1'b0;
      r_frame_end <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_clear     <= w_clear_nxt;
      r_valid     <= w_valid_nxt;
      r_frame_end <= w_frame_end_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Raster position of the next read and its frame-memory address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row  <= '0;
      r_col  <= '0;
      r_addr <= '0;
    end else if (r_state == S_CLEAR) begin
      r_row  <= '0;
      r_col  <= '0;
      r_addr <= '0;
    end else if (w_issue) begin
      if (r_col == POS_LAST) begin
        r_col <= '0;
        r_row <= (r_row == POS_LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
      if (w_interior) begin
        r_addr <= (r_addr == ADDR_LAST) ? '0 : r_addr + 1'b1;
      end
    end
  end

  // Frame memory write port, locked while a frame is in flight
  always_ff @(posedge clk) begin
    if (i_wr_en && !r_busy) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read; border positions load zero and o_data holds between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (w_issue) begin
      r_data <= w_interior ? r_mem[r_addr] : '0;
    end
  end

  assign o_clear      = r_clear;
  assign o_data       = r_data;
  assign o_data_valid = r_valid;
  assign o_frame_end  = r_frame_end;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
endmodule
